id_ex_pipe_reg: RTL and testbench

- ID/EX pipeline register for the 5-stage RV32I core.
- Consumes the ID-stage forwarding selects (forward_data1/forward_data2) and muxes register-file operands against EX/MEM results before latching them into EX.
- Detects load-use hazards and inserts a bubble. Applies branch/jump flushes.
- Keeps stall and flush event counters for performance debug.

---
 rtl/rv32i_pkg.sv | 54 +++++
 rtl/sat_counter.sv | 23 ++
 rtl/id_ex_pipe_reg.sv | 128 ++++++++++++
 tb/tb_id_ex_pipe_reg.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I constants: opcodes, forward-select encodings and the EX control payload.
package rv32i_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned OPCODE_W  = 7;
  localparam int unsigned FUNCT3_W  = 3;
  localparam int unsigned FWD_SEL_W = 2;

  localparam logic [OPCODE_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OPCODE_W-1:0] OP_AUIPC  = 7'b0010111;
  localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPCODE_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_IMM    = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_REG    = 7'b0110011;

  // A bubble decodes as addi x0,x0,0
  localparam logic [OPCODE_W-1:0] NOP_OPCODE = OP_IMM;

  localparam logic [FWD_SEL_W-1:0] FWD_RF  = 2'b00;
  localparam logic [FWD_SEL_W-1:0] FWD_EX  = 2'b01;
  localparam logic [FWD_SEL_W-1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic [OPCODE_W-1:0]  opcode;
    logic [FUNCT3_W-1:0]  funct3;
    logic                 wr_reg_n;
    logic                 valid;
  } ex_ctrl_t;

  localparam ex_ctrl_t EX_CTRL_BUBBLE = '{
    rd:       5'd0,
    opcode:   NOP_OPCODE,
    funct3:   3'd0,
    wr_reg_n: 1'b1,
    valid:    1'b0
  };

  function automatic logic uses_rs1(input logic [OPCODE_W-1:0] op);
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL: uses_rs1 = 1'b0;
      OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG: uses_rs1 = 1'b1;
      default: uses_rs1 = 1'b1;
    endcase
  endfunction

  function automatic logic uses_rs2(input logic [OPCODE_W-1:0] op);
    uses_rs2 = (op == OP_REG) || (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: operand forwarding mux, load-use bubble, flush bubble
// and saturating stall/flush event counters.
module id_ex_pipe_reg
  import rv32i_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  pc_id,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic [4:0]       rd_id,
  input  logic [6:0]       opcode_id,
  input  logic [2:0]       funct3_id,
  input  logic [XLEN-1:0]  imm_id,
  input  logic             wr_reg_n_id,
  input  logic [XLEN-1:0]  rf_data1,
  input  logic [XLEN-1:0]  rf_data2,
  input  logic [1:0]       forward_data1,
  input  logic [1:0]       forward_data2,
  input  logic [XLEN-1:0]  fwd_ex_val,
  input  logic [XLEN-1:0]  fwd_mem_val,
  input  logic             flush,
  output logic [XLEN-1:0]  pc_ex,
  output logic [XLEN-1:0]  a_ex,
  output logic [XLEN-1:0]  b_ex,
  output logic [XLEN-1:0]  imm_ex,
  output logic [4:0]       rd_ex,
  output logic [6:0]       opcode_ex,
  output logic [2:0]       funct3_ex,
  output logic             wr_reg_n_ex,
  output logic             valid_ex,
  output logic             stall_id,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic [XLEN-1:0] r_imm;
  ex_ctrl_t        r_ctrl;

  logic [XLEN-1:0] w_op1;
  logic [XLEN-1:0] w_op2;
  logic            w_load_use;
  logic            w_bubble;
  logic            w_stall_inc;

  // Operand select; x0 is not re-checked, the forwarding unit never targets it
  always_comb begin
    w_op1 = rf_data1;
    case (forward_data1)
      FWD_EX:  w_op1 = fwd_ex_val;
      FWD_MEM: w_op1 = fwd_mem_val;
      FWD_RF:  w_op1 = rf_data1;
      default: w_op1 = rf_data1;
    endcase
    w_op2 = rf_data2;
    case (forward_data2)
      FWD_EX:  w_op2 = fwd_ex_val;
      FWD_MEM: w_op2 = fwd_mem_val;
      FWD_RF:  w_op2 = rf_data2;
      default: w_op2 = rf_data2;
    endcase
  end

  always_comb begin
    w_load_use = r_ctrl.valid && (r_ctrl.opcode == OP_LOAD) && !r_ctrl.wr_reg_n &&
                 (r_ctrl.rd != 5'd0) &&
                 ((uses_rs1(opcode_id) && (rs1_id == r_ctrl.rd)) ||
                  (uses_rs2(opcode_id) && (rs2_id == r_ctrl.rd)));
  end

  assign w_stall_inc = w_load_use && !flush;
  assign w_bubble    = flush || w_load_use;
  assign stall_id    = w_stall_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc   <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_imm  <= '0;
      r_ctrl <= EX_CTRL_BUBBLE;
    end else if (w_bubble) begin
      r_pc   <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_imm  <= '0;
      r_ctrl <= EX_CTRL_BUBBLE;
    end else begin
      r_pc   <= pc_id;
      r_a    <= w_op1;
      r_b    <= w_op2;
      r_imm  <= imm_id;
      r_ctrl <= '{rd: rd_id, opcode: opcode_id, funct3: funct3_id,
                  wr_reg_n: wr_reg_n_id, valid: 1'b1};
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_stall_inc),
    .o_cnt (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (flush),
    .o_cnt (flush_cnt)
  );

  assign pc_ex       = r_pc;
  assign a_ex        = r_a;
  assign b_ex        = r_b;
  assign imm_ex      = r_imm;
  assign rd_ex       = r_ctrl.rd;
  assign opcode_ex   = r_ctrl.opcode;
  assign funct3_ex   = r_ctrl.funct3;
  assign wr_reg_n_ex = r_ctrl.wr_reg_n;
  assign valid_ex    = r_ctrl.valid;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed bench for id_ex_pipe_reg; a second narrow-counter instance exercises saturation.
module tb_id_ex_pipe_reg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned CNT_W   = 32;
  localparam int unsigned SCNT_W  = 3;

  localparam logic [6:0] OPC_LUI  = 7'b0110111;
  localparam logic [6:0] OPC_LOAD = 7'b0000011;
  localparam logic [6:0] OPC_IMM  = 7'b0010011;
  localparam logic [6:0] OPC_REG  = 7'b0110011;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [XLEN-1:0]  pc_id, imm_id, rf_data1, rf_data2, fwd_ex_val, fwd_mem_val;
  logic [4:0]       rs1_id, rs2_id, rd_id;
  logic [6:0]       opcode_id;
  logic [2:0]       funct3_id;
  logic             wr_reg_n_id, flush;
  logic [1:0]       forward_data1, forward_data2;

  logic [XLEN-1:0]  pc_ex, a_ex, b_ex, imm_ex;
  logic [4:0]       rd_ex;
  logic [6:0]       opcode_ex;
  logic [2:0]       funct3_ex;
  logic             wr_reg_n_ex, valid_ex, stall_id;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  logic [XLEN-1:0]   s_pc_ex, s_a_ex, s_b_ex, s_imm_ex;
  logic [4:0]        s_rd_ex;
  logic [6:0]        s_opcode_ex;
  logic [2:0]        s_funct3_ex;
  logic              s_wr_reg_n_ex, s_valid_ex, s_stall_id;
  logic [SCNT_W-1:0] s_stall_cnt, s_flush_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  id_ex_pipe_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .pc_id(pc_id), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rd_id(rd_id), .opcode_id(opcode_id), .funct3_id(funct3_id), .imm_id(imm_id),
    .wr_reg_n_id(wr_reg_n_id), .rf_data1(rf_data1), .rf_data2(rf_data2),
    .forward_data1(forward_data1), .forward_data2(forward_data2),
    .fwd_ex_val(fwd_ex_val), .fwd_mem_val(fwd_mem_val), .flush(flush),
    .pc_ex(pc_ex), .a_ex(a_ex), .b_ex(b_ex), .imm_ex(imm_ex), .rd_ex(rd_ex),
    .opcode_ex(opcode_ex), .funct3_ex(funct3_ex), .wr_reg_n_ex(wr_reg_n_ex),
    .valid_ex(valid_ex), .stall_id(stall_id), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  id_ex_pipe_reg #(.XLEN(XLEN), .CNT_W(SCNT_W)) dut_sat (
    .clk(clk), .rst_n(rst_n), .pc_id(pc_id), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rd_id(rd_id), .opcode_id(opcode_id), .funct3_id(funct3_id), .imm_id(imm_id),
    .wr_reg_n_id(wr_reg_n_id), .rf_data1(rf_data1), .rf_data2(rf_data2),
    .forward_data1(forward_data1), .forward_data2(forward_data2),
    .fwd_ex_val(fwd_ex_val), .fwd_mem_val(fwd_mem_val), .flush(flush),
    .pc_ex(s_pc_ex), .a_ex(s_a_ex), .b_ex(s_b_ex), .imm_ex(s_imm_ex), .rd_ex(s_rd_ex),
    .opcode_ex(s_opcode_ex), .funct3_ex(s_funct3_ex), .wr_reg_n_ex(s_wr_reg_n_ex),
    .valid_ex(s_valid_ex), .stall_id(s_stall_id), .stall_cnt(s_stall_cnt),
    .flush_cnt(s_flush_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic [6:0] op, input logic wrn);
    pc_id = pc; rs1_id = rs1; rs2_id = rs2; rd_id = rd;
    opcode_id = op; funct3_id = 3'd0; wr_reg_n_id = wrn; imm_id = 32'h0000_0000;
    forward_data1 = 2'b00; forward_data2 = 2'b00;
  endtask

  task automatic check_bubble(input string tag);
    check({tag, "_valid"},  32'(valid_ex),    32'd0);
    check({tag, "_wrn"},    32'(wr_reg_n_ex), 32'd1);
    check({tag, "_opcode"}, 32'(opcode_ex),   32'h13);
    check({tag, "_rd"},     32'(rd_ex),       32'd0);
  endtask

  initial begin
    logic [1:0] sel;
    logic [31:0] exp_a, exp_b;

    rst_n = 1'b0; flush = 1'b0;
    rf_data1 = 32'h11; rf_data2 = 32'h44; fwd_ex_val = 32'h22; fwd_mem_val = 32'h33;
    set_instr(32'h100, 5'd1, 5'd2, 5'd3, OPC_REG, 1'b0);
    #12;
    check_bubble("rst");
    check("rst_pc", pc_ex, 32'd0);
    check("rst_stall_cnt", stall_cnt, 32'd0);
    check("rst_flush_cnt", flush_cnt, 32'd0);
    rst_n = 1'b1;
    tick();

    // Forward mux on both operands, plus field latching
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      forward_data1 = sel; forward_data2 = sel;
      imm_id = 32'h0000_0abc + 32'(i);
      tick();
      case (sel)
        2'b01:   begin exp_a = 32'h22; exp_b = 32'h22; end
        2'b10:   begin exp_a = 32'h33; exp_b = 32'h33; end
        default: begin exp_a = 32'h11; exp_b = 32'h44; end
      endcase
      check($sformatf("fwd_a_sel%0d", i), a_ex, exp_a);
      check($sformatf("fwd_b_sel%0d", i), b_ex, exp_b);
      check($sformatf("fwd_imm_%0d", i), imm_ex, 32'h0000_0abc + 32'(i));
    end
    check("lat_pc", pc_ex, 32'h100);
    check("lat_rd", 32'(rd_ex), 32'd3);
    check("lat_opcode", 32'(opcode_ex), 32'h33);
    check("lat_valid", 32'(valid_ex), 32'd1);
    check("lat_wrn", 32'(wr_reg_n_ex), 32'd0);

    // Asynchronous reset mid-cycle
    #2 rst_n = 1'b0;
    #1;
    check_bubble("mid_rst");
    check("mid_rst_a", a_ex, 32'd0);
    rst_n = 1'b1;

    // Load-use on rs1: lw x8, then add x9,x8,x1
    set_instr(32'h200, 5'd2, 5'd0, 5'd8, OPC_LOAD, 1'b0);
    tick();
    check("lw_in_ex_rd", 32'(rd_ex), 32'd8);
    set_instr(32'h204, 5'd8, 5'd1, 5'd9, OPC_REG, 1'b0);
    #1;
    check("lu1_stall", 32'(stall_id), 32'd1);
    tick();
    check_bubble("lu1_bub");
    check("lu1_stall_cnt", stall_cnt, 32'd1);
    check("lu1_stall_drop", 32'(stall_id), 32'd0);
    forward_data1 = 2'b10;
    tick();
    check("lu1_valid", 32'(valid_ex), 32'd1);
    check("lu1_a_mem", a_ex, 32'h33);
    check("lu1_rd", 32'(rd_ex), 32'd9);

    // Load-use on rs2
    set_instr(32'h208, 5'd2, 5'd0, 5'd8, OPC_LOAD, 1'b0);
    tick();
    set_instr(32'h20c, 5'd1, 5'd8, 5'd10, OPC_REG, 1'b0);
    #1;
    check("lu2_stall", 32'(stall_id), 32'd1);
    tick();
    check("lu2_stall_cnt", stall_cnt, 32'd2);
    forward_data2 = 2'b10;
    tick();
    check("lu2_b_mem", b_ex, 32'h33);
    check("lu2_a_rf", a_ex, 32'h11);

    // No false stalls
    set_instr(32'h300, 5'd2, 5'd0, 5'd8, OPC_LOAD, 1'b0);
    tick();
    set_instr(32'h304, 5'd8, 5'd8, 5'd8, OPC_LUI, 1'b0);
    #1;
    check("nf_lui", 32'(stall_id), 32'd0);
    set_instr(32'h304, 5'd1, 5'd8, 5'd5, OPC_IMM, 1'b0);
    #1;
    check("nf_imm_rs2", 32'(stall_id), 32'd0);
    set_instr(32'h308, 5'd2, 5'd0, 5'd0, OPC_LOAD, 1'b0);
    tick();
    set_instr(32'h30c, 5'd0, 5'd0, 5'd1, OPC_REG, 1'b0);
    #1;
    check("nf_lw_x0", 32'(stall_id), 32'd0);
    tick();
    check("nf_cnt", stall_cnt, 32'd2);

    // Flush beats a load-use hazard
    set_instr(32'h400, 5'd2, 5'd0, 5'd8, OPC_LOAD, 1'b0);
    tick();
    set_instr(32'h404, 5'd8, 5'd1, 5'd9, OPC_REG, 1'b0);
    flush = 1'b1;
    #1;
    check("fl_stall", 32'(stall_id), 32'd0);
    tick();
    flush = 1'b0;
    check_bubble("fl_bub");
    check("fl_flush_cnt", flush_cnt, 32'd1);
    check("fl_stall_cnt", stall_cnt, 32'd2);

    // Six more load-use events: 8 total, narrow counter pinned at 7
    for (int i = 0; i < 6; i++) begin
      set_instr(32'h500, 5'd2, 5'd0, 5'd8, OPC_LOAD, 1'b0);
      tick();
      set_instr(32'h504, 5'd8, 5'd1, 5'd9, OPC_REG, 1'b0);
      tick();
    end
    check("sat_wide", stall_cnt, 32'd8);
    check("sat_narrow", 32'(s_stall_cnt), 32'd7);
    check("sat_narrow_flush", 32'(s_flush_cnt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
